// File: rtl/byte_serializer.sv
// Parallel-to-serial unloader: accepts one WIDTH-bit word over valid/ready and
// shifts it out one bit per accepted beat, with downstream backpressure and a clock enable.
module byte_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             ser_ready,
    output logic             ser_valid,
    output logic             ser_out,
    output logic             ser_last,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             valid_q;
    logic             last_q;
    logic             busy_q;
    logic             load;
    logic             beat;

    // in_ready is gated by rst directly so it drops the moment reset asserts.
    assign in_ready  = rst & (state_q == IDLE);
    assign load      = in_valid & in_ready & en;
    assign beat      = valid_q & ser_ready & en;

    assign ser_valid = valid_q;
    assign ser_last  = last_q;
    assign busy      = busy_q;
    assign ser_out   = valid_q & (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);

    // Shift toward the output end with zero fill; after WIDTH beats the register is empty.
    always_comb begin
        shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        shreg_q <= in_data;
                        cnt_q   <= '0;
                        last_q  <= 1'b0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (beat) begin
                        shreg_q <= shreg_d;
                        if (last_q) begin
                            cnt_q   <= '0;
                            last_q  <= 1'b0;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q  <= cnt_d;
                            last_q <= (cnt_d == LAST_CNT);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serializer.sv
// Scoreboard bench: two serializers (MSB-first and LSB-first) share one stimulus stream;
// a reference model expands each accepted word into expected bits checked by a monitor.
module tb_byte_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       inValid;
    logic [7:0] inData;
    logic       serReady;

    logic inReadyM, serValidM, serOutM, serLastM, busyM;
    logic inReadyL, serValidL, serOutL, serLastL, busyL;

    typedef struct packed {
        logic bitMsb;
        logic bitLsb;
        logic last;
    } expBeat_t;

    expBeat_t expQ[$];
    int       total      = 0;
    int       bad        = 0;
    int       beatCount  = 0;
    bit       randomMode = 1'b0;

    always #5 clk = ~clk;

    byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dutMsb (
        .clk(clk), .rst(rst), .en(en), .in_valid(inValid), .in_data(inData),
        .in_ready(inReadyM), .ser_ready(serReady), .ser_valid(serValidM),
        .ser_out(serOutM), .ser_last(serLastM), .busy(busyM)
    );

    byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dutLsb (
        .clk(clk), .rst(rst), .en(en), .in_valid(inValid), .in_data(inData),
        .in_ready(inReadyL), .ser_ready(serReady), .ser_valid(serValidL),
        .ser_out(serOutL), .ser_last(serLastL), .busy(busyL)
    );

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%b expected=%b at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a word becomes eight beats, bit order chosen per DUT, last flag on beat 8.
    task automatic pushWord(input logic [7:0] w);
        expBeat_t e;
        for (int i = 0; i < 8; i++) begin
            e.bitMsb = w[7-i];
            e.bitLsb = w[i];
            e.last   = (i == 7);
            expQ.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        expBeat_t f;
        bit       wordLive;
        if (!rst) begin
            checkOutput("rstInReadyM", inReadyM, 1'b0);
            checkOutput("rstInReadyL", inReadyL, 1'b0);
            checkOutput("rstSerValidM", serValidM, 1'b0);
            checkOutput("rstSerOutM", serOutM, 1'b0);
            checkOutput("rstSerLastM", serLastM, 1'b0);
            checkOutput("rstBusyM", busyM, 1'b0);
            checkOutput("rstSerValidL", serValidL, 1'b0);
            checkOutput("rstBusyL", busyL, 1'b0);
            expQ.delete();
        end else begin
            wordLive = (expQ.size() != 0);
            checkOutput("serValidM", serValidM, wordLive);
            checkOutput("serValidL", serValidL, wordLive);
            checkOutput("busyM", busyM, wordLive);
            checkOutput("busyL", busyL, wordLive);
            checkOutput("inReadyM", inReadyM, !wordLive);
            checkOutput("inReadyL", inReadyL, !wordLive);
            if (wordLive) begin
                f = expQ[0];
                checkOutput("serOutM", serOutM, f.bitMsb);
                checkOutput("serOutL", serOutL, f.bitLsb);
                checkOutput("serLastM", serLastM, f.last);
                checkOutput("serLastL", serLastL, f.last);
                if (serReady && en) begin
                    void'(expQ.pop_front());
                    beatCount++;
                end
            end else begin
                checkOutput("idleSerOutM", serOutM, 1'b0);
                checkOutput("idleSerOutL", serOutL, 1'b0);
                checkOutput("idleSerLastM", serLastM, 1'b0);
                checkOutput("idleSerLastL", serLastL, 1'b0);
            end
            if (!wordLive && inValid && en)
                pushWord(inData);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (randomMode) begin
            serReady = 1'($urandom_range(0, 1));
            en       = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] w);
        bit acc;
        acc     = 1'b0;
        inValid = 1'b1;
        inData  = w;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            acc = inReadyM && en;
            tick();
        end
        inValid = 1'b0;
        checkOutput("loadAccepted", acc, 1'b1);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 300; i++) begin
            if (expQ.size() == 0 && !serValidM)
                break;
            tick();
        end
        checkOutput("drainDone", (expQ.size() == 0), 1'b1);
    endtask

    task automatic waitBeats(input int start, input int n);
        for (int i = 0; i < 300; i++) begin
            if (beatCount - start >= n)
                break;
            tick();
        end
        checkOutput("beatsReached", (beatCount - start >= n), 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start;
        rst      = 1'b1;
        en       = 1'b1;
        inValid  = 1'b0;
        inData   = 8'h00;
        serReady = 1'b1;
        #1 rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        checkOutput("inReadyAfterReleaseM", inReadyM, 1'b1);
        checkOutput("inReadyAfterReleaseL", inReadyL, 1'b1);

        // MSB-first and LSB-first orderings of the same word, full speed.
        applyStimulus(8'hC1);
        waitIdle();

        // Backpressure for three cycles while the fourth bit is presented.
        start = beatCount;
        applyStimulus(8'hA5);
        waitBeats(start, 3);
        serReady = 1'b0;
        repeat (3) tick();
        serReady = 1'b1;
        waitIdle();

        // Enable low in IDLE with a pending word must not load it.
        en      = 1'b0;
        inValid = 1'b1;
        inData  = 8'h77;
        repeat (3) tick();
        inValid = 1'b0;
        en      = 1'b1;
        tick();

        // Freeze mid-word, and hold in_valid through SHIFT without a reload.
        start = beatCount;
        applyStimulus(8'h3C);
        inValid = 1'b1;
        inData  = 8'h99;
        waitBeats(start, 1);
        en = 1'b0;
        repeat (2) tick();
        en = 1'b1;
        applyStimulus(8'h99);
        waitIdle();

        // Reset in the middle of a word, then a clean word.
        start = beatCount;
        applyStimulus(8'hFF);
        waitBeats(start, 2);
        rst = 1'b0;
        #1;
        checkOutput("midRstInReadyM", inReadyM, 1'b0);
        checkOutput("midRstSerValidM", serValidM, 1'b0);
        checkOutput("midRstSerOutM", serOutM, 1'b0);
        checkOutput("midRstSerLastM", serLastM, 1'b0);
        checkOutput("midRstBusyM", busyM, 1'b0);
        checkOutput("midRstSerValidL", serValidL, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        checkOutput("midRstReleaseInReadyM", inReadyM, 1'b1);
        applyStimulus(8'h5A);
        waitIdle();

        // Random words under random backpressure and enable gating.
        randomMode = 1'b1;
        for (int n = 0; n < 25; n++)
            applyStimulus(8'($urandom_range(0, 255)));
        waitIdle();
        randomMode = 1'b0;
        en       = 1'b1;
        serReady = 1'b1;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
